result_stream: RTL and testbench



---
 rtl/result_stream_pkg.sv | 15 +
 rtl/result_stream.sv | 143 ++++++++++++++
 tb/tb_result_stream.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_stream_pkg.sv
// Shared constants and helpers for the result stream consumer.
package result_stream_pkg;

    // Config address of the row length register (mirrors cfg_parameters.vh).
    localparam int unsigned CFG_RESULT = 6;

    // Width of the row length field and of the per-row result counter.
    localparam int unsigned ROW_LEN_W = 16;

    // Bits needed to count 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/result_stream.sv
// Accepts result vectors into a two-slot buffer and serializes them as STR_WIDTH words,
// flagging the final word of each configured output row.
module result_stream
    import result_stream_pkg::*;
#(
    parameter int unsigned CFG_DWIDTH = 32,
    parameter int unsigned CFG_AWIDTH = 5,
    parameter int unsigned DEPTH_NB   = 16,
    parameter int unsigned IMG_WIDTH  = 16,
    parameter int unsigned STR_WIDTH  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CFG_DWIDTH-1:0]         cfg_data,
    input  logic [CFG_AWIDTH-1:0]         cfg_addr,
    input  logic                          cfg_valid,
    input  logic [DEPTH_NB*IMG_WIDTH-1:0] result_bus,
    input  logic                          result_val,
    output logic                          result_rdy,
    output logic [STR_WIDTH-1:0]          str_data,
    output logic                          str_last,
    output logic                          str_val,
    input  logic                          str_rdy
);

    localparam int unsigned VEC_W = DEPTH_NB * IMG_WIDTH;
    localparam int unsigned WORDS = VEC_W / STR_WIDTH;
    localparam int unsigned WCW   = cnt_width(WORDS);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS - 1);

    logic [VEC_W-1:0]     slot_q [2];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [1:0]           count_q, count_d;
    logic [WCW-1:0]       word_cnt_q, word_cnt_d;
    logic [ROW_LEN_W-1:0] res_cnt_q, res_cnt_d;
    logic [ROW_LEN_W-1:0] row_len_q, row_len_d;
    logic [ROW_LEN_W-1:0] row_last;
    logic [STR_WIDTH-1:0] str_data_q, str_data_d;
    logic                 str_last_q, str_last_d;
    logic                 str_val_q, str_val_d;
    logic [STR_WIDTH-1:0] cur_word;
    logic                 cfg_hit, accept, stage_load, slot_release, row_close;
    logic                 unused_cfg_bits;

    // Upper config bits carry other fields of the shared register map.
    assign unused_cfg_bits = ^cfg_data[CFG_DWIDTH-1:ROW_LEN_W];

    assign result_rdy = ~rst & (count_q != 2'd2);
    assign accept     = result_val & result_rdy;
    assign stage_load = ~str_val_q | str_rdy;
    assign cfg_hit    = cfg_valid & (cfg_addr == CFG_AWIDTH'(CFG_RESULT));
    assign row_len_d  = cfg_hit ? cfg_data[ROW_LEN_W-1:0] : row_len_q;

    // A row length of 0 is treated as 1; >= lets a shrunken row_len close the row at once.
    assign row_last  = (row_len_q == '0) ? '0 : row_len_q - ROW_LEN_W'(1);
    assign row_close = (res_cnt_q >= row_last);

    assign cur_word = slot_q[rd_ptr_q][32'(word_cnt_q) * STR_WIDTH +: STR_WIDTH];

    assign str_data = str_data_q;
    assign str_last = str_last_q;
    assign str_val  = str_val_q;

    // Next state for the buffer pointers, counters and output stage.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        word_cnt_d   = word_cnt_q;
        res_cnt_d    = res_cnt_q;
        str_data_d   = str_data_q;
        str_last_d   = str_last_q;
        str_val_d    = str_val_q;
        slot_release = 1'b0;

        if (stage_load) begin
            str_val_d  = (count_q != 2'd0);
            str_last_d = 1'b0;
            if (count_q != 2'd0) begin
                str_data_d = cur_word;
                if (word_cnt_q == LAST_WORD) begin
                    slot_release = 1'b1;
                    rd_ptr_d     = ~rd_ptr_q;
                    word_cnt_d   = '0;
                    str_last_d   = row_close;
                    res_cnt_d    = row_close ? '0 : res_cnt_q + ROW_LEN_W'(1);
                end else begin
                    word_cnt_d = word_cnt_q + WCW'(1);
                end
            end
        end

        if (accept) begin
            wr_ptr_d = ~wr_ptr_q;
        end

        unique case ({accept, slot_release})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Control state with synchronous reset; str_data is left unreset.
    always_ff @(posedge clk) begin
        str_data_q <= str_data_d;
        if (rst) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            word_cnt_q <= '0;
            res_cnt_q  <= '0;
            row_len_q  <= ROW_LEN_W'(1);
            str_last_q <= 1'b0;
            str_val_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            word_cnt_q <= word_cnt_d;
            res_cnt_q  <= res_cnt_d;
            row_len_q  <= row_len_d;
            str_last_q <= str_last_d;
            str_val_q  <= str_val_d;
        end
    end

    // Slot storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (accept) begin
            slot_q[wr_ptr_q] <= result_bus;
        end
    end

    // Occupancy bound, no accept into a full buffer, and a stalled output holds.
    a_count_max: assert property (@(posedge clk) disable iff (rst) count_q <= 2'd2);
    a_no_full_accept: assert property (@(posedge clk) disable iff (rst)
        !(accept && (count_q == 2'd2)));
    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (str_val_q && !str_rdy) |=> (str_val_q && $stable(str_data_q) && $stable(str_last_q)));

endmodule

// File: tb/tb_result_stream.sv
// Directed bench for result_stream: reset, single vector, row marking, backpressure,
// random stall, reset mid-drain and row length edge cases.
`timescale 1ns/1ps
module tb_result_stream;
    import result_stream_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  cfg_data;
    logic [4:0]   cfg_addr;
    logic         cfg_valid;
    logic [255:0] result_bus;
    logic         result_val;
    logic         result_rdy;
    logic [63:0]  str_data;
    logic         str_last;
    logic         str_val;
    logic         str_rdy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [64:0]  obs_q[$];
    int           obs_cyc[$];
    int           acc_cyc[$];
    logic [255:0] sent_q[$];
    int           rdy_low_run = 0;
    int           rdy_low_max = 0;

    result_stream #(
        .CFG_DWIDTH(32),
        .CFG_AWIDTH(5),
        .DEPTH_NB  (16),
        .IMG_WIDTH (16),
        .STR_WIDTH (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_data  (cfg_data),
        .cfg_addr  (cfg_addr),
        .cfg_valid (cfg_valid),
        .result_bus(result_bus),
        .result_val(result_val),
        .result_rdy(result_rdy),
        .str_data  (str_data),
        .str_last  (str_last),
        .str_val   (str_val),
        .str_rdy   (str_rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes seen at the negedge complete on the following posedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (str_val && str_rdy) begin
                obs_q.push_back({str_last, str_data});
                obs_cyc.push_back(cyc);
            end
            if (result_val && result_rdy) acc_cyc.push_back(cyc);
            if (!result_rdy) begin
                rdy_low_run++;
                if (rdy_low_run > rdy_low_max) rdy_low_max = rdy_low_run;
            end else begin
                rdy_low_run = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        obs_q.delete();
        obs_cyc.delete();
        acc_cyc.delete();
        sent_q.delete();
        rdy_low_run = 0;
        rdy_low_max = 0;
    endtask

    task automatic pad_logs(input int n);
        while (obs_q.size() < n) obs_q.push_back('0);
        while (obs_cyc.size() < n) obs_cyc.push_back(-100);
        while (acc_cyc.size() < n) acc_cyc.push_back(-200);
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        result_val = 1'b0;
        cfg_valid  = 1'b0;
        step();
        step();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic write_row_len(input logic [15:0] len);
        cfg_addr  = 5'(CFG_RESULT);
        cfg_data  = {16'hDEAD, len};
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    function automatic logic [255:0] make_vec(input int base);
        logic [255:0] v;
        for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'(base + i);
        return v;
    endfunction

    function automatic logic [63:0] exp_word(input int idx);
        logic [255:0] v;
        v = (idx / 4 < sent_q.size()) ? sent_q[idx / 4] : '0;
        return v[(idx % 4) * 64 +: 64];
    endfunction

    task automatic drive_vec(input logic [255:0] v, output bit ok);
        int n;
        bit rdy;
        n  = 0;
        ok = 1'b0;
        result_bus = v;
        result_val = 1'b1;
        sent_q.push_back(v);
        while (!ok && n < 200) begin
            rdy = result_rdy;
            step();
            n++;
            if (rdy) ok = 1'b1;
        end
        result_val = 1'b0;
    endtask

    task automatic wait_words(input int n, output bit ok);
        int k;
        k = 0;
        while (obs_q.size() < n && k < 500) begin
            step();
            k++;
        end
        ok = (obs_q.size() >= n);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        result_val = 1'b0;
        result_bus = '0;
        cfg_valid  = 1'b0;
        cfg_addr   = '0;
        cfg_data   = '0;
        str_rdy    = 1'b1;
        step();
        step();
        total++;
        if (result_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b exp=0", result_rdy); end
        total++;
        if (str_val !== 1'b0) begin bad++; $display("FAIL reset_val got=%b exp=0", str_val); end
        total++;
        if (str_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", str_last); end
        rst = 1'b0;
        #1;
        total++;
        if (result_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy_after got=%b exp=1", result_rdy); end
        step();
        total++;
        if (str_val !== 1'b0) begin bad++; $display("FAIL reset_idle_val got=%b exp=0", str_val); end
    endtask

    task automatic test_single();
        bit ok;
        logic [3:0] lasts;
        apply_reset();
        write_row_len(16'd1);
        str_rdy = 1'b1;
        clear_logs();
        drive_vec(make_vec(0), ok);
        total++;
        if (!ok) begin bad++; $display("FAIL single_accept got=0 exp=1"); end
        wait_words(4, ok);
        repeat (5) step();
        total++;
        if (obs_q.size() != 4) begin bad++; $display("FAIL single_count got=%0d exp=4", obs_q.size()); end
        pad_logs(4);
        total++;
        if (obs_q[0][63:0] !== 64'h0003000200010000)
            begin bad++; $display("FAIL single_w0 got=%h exp=0003000200010000", obs_q[0][63:0]); end
        total++;
        if (obs_q[1][63:0] !== 64'h0007000600050004)
            begin bad++; $display("FAIL single_w1 got=%h exp=0007000600050004", obs_q[1][63:0]); end
        total++;
        if (obs_q[2][63:0] !== 64'h000B000A00090008)
            begin bad++; $display("FAIL single_w2 got=%h exp=000B000A00090008", obs_q[2][63:0]); end
        total++;
        if (obs_q[3][63:0] !== 64'h000F000E000D000C)
            begin bad++; $display("FAIL single_w3 got=%h exp=000F000E000D000C", obs_q[3][63:0]); end
        lasts = {obs_q[3][64], obs_q[2][64], obs_q[1][64], obs_q[0][64]};
        total++;
        if (lasts !== 4'b1000) begin bad++; $display("FAIL single_last got=%b exp=1000", lasts); end
        total++;
        if (obs_cyc[0] - acc_cyc[0] != 2)
            begin bad++; $display("FAIL single_latency got=%0d exp=2", obs_cyc[0] - acc_cyc[0]); end
        total++;
        if (str_val !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", str_val); end
    endtask

    task automatic test_row_marking();
        bit ok;
        bit exp_last;
        apply_reset();
        write_row_len(16'd3);
        str_rdy = 1'b1;
        clear_logs();
        for (int k = 0; k < 6; k++) begin
            drive_vec(make_vec(16'h1000 * (k + 1)), ok);
            total++;
            if (!ok) begin bad++; $display("FAIL row_accept_%0d got=0 exp=1", k); end
        end
        wait_words(24, ok);
        repeat (3) step();
        total++;
        if (obs_q.size() != 24) begin bad++; $display("FAIL row_count got=%0d exp=24", obs_q.size()); end
        pad_logs(24);
        for (int i = 0; i < 24; i++) begin
            exp_last = (i == 11) || (i == 23);
            total++;
            if (obs_q[i] !== {exp_last, exp_word(i)})
                begin bad++; $display("FAIL row_word_%0d got=%h exp=%h", i, obs_q[i], {exp_last, exp_word(i)}); end
            if (i > 0) begin
                total++;
                if (obs_cyc[i] - obs_cyc[i-1] != 1)
                    begin bad++; $display("FAIL row_gap_%0d got=%0d exp=1", i, obs_cyc[i] - obs_cyc[i-1]); end
            end
        end
        total++;
        if (rdy_low_max > 4) begin bad++; $display("FAIL row_rdy_low got=%0d exp<=4", rdy_low_max); end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit ok_v [3];
        logic [63:0] hold_data;
        logic [63:0] head;
        logic [255:0] v0;
        logic hold_last;
        apply_reset();
        write_row_len(16'd1);
        str_rdy = 1'b0;
        clear_logs();
        v0   = make_vec(16'h2000);
        head = v0[63:0];
        fork
            begin
                for (int k = 0; k < 3; k++) drive_vec(make_vec(16'h2000 + k * 16), ok_v[k]);
            end
            begin
                repeat (10) step();
                total++;
                if (acc_cyc.size() != 2) begin bad++; $display("FAIL bp_accepts got=%0d exp=2", acc_cyc.size()); end
                total++;
                if (result_rdy !== 1'b0) begin bad++; $display("FAIL bp_rdy got=%b exp=0", result_rdy); end
                total++;
                if (result_val !== 1'b1) begin bad++; $display("FAIL bp_val_held got=%b exp=1", result_val); end
                total++;
                if (str_val !== 1'b1) begin bad++; $display("FAIL bp_str_val got=%b exp=1", str_val); end
                hold_data = str_data;
                hold_last = str_last;
                total++;
                if (hold_data !== head) begin bad++; $display("FAIL bp_head got=%h exp=%h", hold_data, head); end
                repeat (3) step();
                total++;
                if ({str_val, str_last, str_data} !== {1'b1, hold_last, hold_data})
                    begin bad++; $display("FAIL bp_stable got=%h exp=%h", {str_val, str_last, str_data},
                                          {1'b1, hold_last, hold_data}); end
                str_rdy = 1'b1;
            end
        join
        wait_words(12, ok);
        repeat (3) step();
        total++;
        if (!(ok_v[0] && ok_v[1] && ok_v[2]))
            begin bad++; $display("FAIL bp_all_accepted got=%b%b%b exp=111", ok_v[0], ok_v[1], ok_v[2]); end
        total++;
        if (obs_q.size() != 12) begin bad++; $display("FAIL bp_count got=%0d exp=12", obs_q.size()); end
        total++;
        if (acc_cyc.size() != 3) begin bad++; $display("FAIL bp_accept_count got=%0d exp=3", acc_cyc.size()); end
        pad_logs(12);
        for (int i = 0; i < 12; i++) begin
            total++;
            if (obs_q[i] !== {(i % 4 == 3), exp_word(i)})
                begin bad++; $display("FAIL bp_word_%0d got=%h exp=%h", i, obs_q[i], {(i % 4 == 3), exp_word(i)}); end
        end
        total++;
        if (acc_cyc[2] != obs_cyc[3])
            begin bad++; $display("FAIL bp_third_accept got=%0d exp=%0d", acc_cyc[2], obs_cyc[3]); end
    endtask

    task automatic test_random_stall();
        bit ok;
        bit drv_done;
        bit exp_last;
        int acc_fail;
        apply_reset();
        write_row_len(16'd2);
        clear_logs();
        drv_done = 1'b0;
        acc_fail = 0;
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    drive_vec(make_vec(16'h4000 + k * 16), ok);
                    if (!ok) acc_fail++;
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    str_rdy = 1'($urandom_range(0, 1));
                    step();
                end
            end
        join
        str_rdy = 1'b1;
        wait_words(80, ok);
        repeat (3) step();
        total++;
        if (acc_fail != 0) begin bad++; $display("FAIL rnd_accept got=%0d exp=0", acc_fail); end
        total++;
        if (obs_q.size() != 80) begin bad++; $display("FAIL rnd_count got=%0d exp=80", obs_q.size()); end
        pad_logs(80);
        for (int i = 0; i < 80; i++) begin
            exp_last = (i % 4 == 3) && ((i / 4) % 2 == 1);
            total++;
            if (obs_q[i] !== {exp_last, exp_word(i)})
                begin bad++; $display("FAIL rnd_word_%0d got=%h exp=%h", i, obs_q[i], {exp_last, exp_word(i)}); end
        end
    endtask

    task automatic test_reset_mid_drain();
        bit ok;
        apply_reset();
        write_row_len(16'd2);
        str_rdy = 1'b1;
        clear_logs();
        drive_vec(make_vec(16'h5000), ok);
        wait_words(4, ok);
        drive_vec(make_vec(16'h5100), ok);
        wait_words(6, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rmd_pre_words got=%0d exp=6", obs_q.size()); end
        rst = 1'b1;
        step();
        total++;
        if (str_val !== 1'b0) begin bad++; $display("FAIL rmd_val got=%b exp=0", str_val); end
        total++;
        if (str_last !== 1'b0) begin bad++; $display("FAIL rmd_last got=%b exp=0", str_last); end
        total++;
        if (result_rdy !== 1'b0) begin bad++; $display("FAIL rmd_rdy_in_rst got=%b exp=0", result_rdy); end
        rst = 1'b0;
        #1;
        total++;
        if (result_rdy !== 1'b1) begin bad++; $display("FAIL rmd_rdy got=%b exp=1", result_rdy); end
        repeat (6) step();
        total++;
        if (obs_q.size() != 6) begin bad++; $display("FAIL rmd_dropped got=%0d exp=6", obs_q.size()); end
        write_row_len(16'd2);
        clear_logs();
        drive_vec(make_vec(16'h5200), ok);
        drive_vec(make_vec(16'h5300), ok);
        wait_words(8, ok);
        repeat (3) step();
        total++;
        if (obs_q.size() != 8) begin bad++; $display("FAIL rmd_count got=%0d exp=8", obs_q.size()); end
        pad_logs(8);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (obs_q[i] !== {(i == 7), exp_word(i)})
                begin bad++; $display("FAIL rmd_word_%0d got=%h exp=%h", i, obs_q[i], {(i == 7), exp_word(i)}); end
        end
    endtask

    task automatic test_config_edge();
        bit ok;
        bit exp_last;
        int j;
        apply_reset();
        write_row_len(16'd0);
        str_rdy = 1'b1;
        clear_logs();
        for (int k = 0; k < 3; k++) drive_vec(make_vec(16'h6000 + k * 16), ok);
        wait_words(12, ok);
        repeat (3) step();
        total++;
        if (obs_q.size() != 12) begin bad++; $display("FAIL cfg0_count got=%0d exp=12", obs_q.size()); end
        pad_logs(12);
        for (int i = 0; i < 12; i++) begin
            total++;
            if (obs_q[i][64] !== (i % 4 == 3))
                begin bad++; $display("FAIL cfg0_last_%0d got=%b exp=%b", i, obs_q[i][64], (i % 4 == 3)); end
        end
        write_row_len(16'd8);
        clear_logs();
        for (int k = 0; k < 4; k++) drive_vec(make_vec(16'h7000 + k * 16), ok);
        wait_words(16, ok);
        repeat (3) step();
        write_row_len(16'd2);
        for (int k = 4; k < 7; k++) drive_vec(make_vec(16'h7000 + k * 16), ok);
        wait_words(28, ok);
        repeat (3) step();
        total++;
        if (obs_q.size() != 28) begin bad++; $display("FAIL cfg2_count got=%0d exp=28", obs_q.size()); end
        pad_logs(28);
        for (int i = 0; i < 28; i++) begin
            j = i / 4;
            exp_last = (i % 4 == 3) && (j == 4 || j == 6);
            total++;
            if (obs_q[i] !== {exp_last, exp_word(i)})
                begin bad++; $display("FAIL cfg2_word_%0d got=%h exp=%h", i, obs_q[i], {exp_last, exp_word(i)}); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_row_marking();
        test_backpressure();
        test_random_stall();
        test_reset_mid_drain();
        test_config_edge();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
